// File: rtl/decryption_sub_block.sv
// -----------------------------------------------------------------------------
// decryption_sub_block
//   One AES-128 inverse-cipher round, pipelined over two register stages:
//     stage 1 : InvSubBytes(InvShiftRows(input_text)), plus round_key, last_round
//     stage 2 : (s1_data ^ s1_key), then InvMixColumns unless last_round was set
//   A valid/ready handshake lets the block be iterated or chained.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (clears every register)
//   in_valid     input_text / round_key / last_round are valid this cycle
//   in_ready     block accepts an input this cycle (never depends on in_valid)
//   input_text   128-bit state; byte0 = [127:120], byte i = row i%4, col i/4
//   round_key    128-bit round key, same byte order
//   last_round   1 = final inverse round, InvMixColumns bypassed
//   out_valid    output_text holds a round result
//   out_ready    downstream accepts output_text this cycle
//   output_text  128-bit round result, held stable while stalled
// -----------------------------------------------------------------------------
module decryption_sub_block (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] input_text,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] output_text
);

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x (0x02) in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the [0e 0b 0d 09] circulant; 9/b/d/e are built from
  // the x2/x4/x8 chain so no general multiplier is needed.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2[k] = xtime(a[k]);
      x4[k] = xtime(x2[k]);
      x8[k] = xtime(x4[k]);
      m9[k] = x8[k] ^ a[k];
      mb[k] = x8[k] ^ x2[k] ^ a[k];
      md[k] = x8[k] ^ x4[k] ^ a[k];
      me[k] = x8[k] ^ x4[k] ^ x2[k];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Pipeline state
  logic         s1_valid_q, s1_valid_d;
  logic [127:0] s1_data_q,  s1_data_d;
  logic [127:0] s1_key_q,   s1_key_d;
  logic         s1_last_q,  s1_last_d;
  logic         s2_valid_q, s2_valid_d;
  logic [127:0] s2_data_q,  s2_data_d;

  logic         adv1, adv2;
  logic [127:0] shifted;     // InvShiftRows(input_text)
  logic [127:0] sub_bytes;   // InvSubBytes(shifted)
  logic [127:0] key_added;   // stage-1 state XOR round key
  logic [127:0] mixed;       // InvMixColumns(key_added)
  logic [127:0] round_out;

  // InvShiftRows: row r rotates right by r, new[r][c] = old[r][(c-r) mod 4].
  // InvSubBytes: one table lookup per byte.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(r+4*c) -: 8]   = input_text[127-8*(r+4*((c-r+4)%4)) -: 8];
      assign sub_bytes[127-8*(r+4*c) -: 8] = INV_SBOX[shifted[127-8*(r+4*c) -: 8]];
    end
    assign mixed[127-32*c -: 32] = inv_mix_column(key_added[127-32*c -: 32]);
  end

  assign key_added = s1_data_q ^ s1_key_q;
  assign round_out = s1_last_q ? key_added : mixed;

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no path
    // leaves one unassigned and no latch is inferred.
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    s1_last_d  = s1_last_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;

    // A stage advances when it is empty or the stage after it is moving.
    adv2 = !s2_valid_q || out_ready;
    adv1 = !s1_valid_q || adv2;

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      // Data only moves with a valid beat, so output_text keeps its last
      // result while out_valid is low.
      if (s1_valid_q) s2_data_d = round_out;
    end

    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = sub_bytes;
        s1_key_d  = round_key;
        s1_last_d = last_round;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the datapath registers are cleared too, because output_text
      // must read zero after reset, not just out_valid.
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      s1_last_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_key_q   <= s1_key_d;
      s1_last_q  <= s1_last_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
    end
  end

  assign in_ready    = adv1;
  assign out_valid   = s2_valid_q;
  assign output_text = s2_data_q;

endmodule

// File: tb/tb_decryption_sub_block.sv
// -----------------------------------------------------------------------------
// tb_decryption_sub_block
//   Directed table vectors, hand-written handshake sequences and a randomised
//   stream checked against an independent inverse-round model. The model
//   derives its inverse S-box from GF(2^8) inversion plus the forward affine
//   map, and uses a generic GF multiplier for InvMixColumns.
// -----------------------------------------------------------------------------
module tb_decryption_sub_block;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] input_text;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] output_text;

  always #5 clk = ~clk;

  decryption_sub_block dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_text  (input_text),
    .round_key   (round_key),
    .last_round  (last_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_text (output_text)
  );

  typedef struct packed {
    logic [127:0] in_text;
    logic [127:0] key;
    logic         last;
    logic [127:0] exp;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           n_out  = 0;
  logic [7:0]   inv_tab [256];
  vec_t         vecs [8];
  vec_t         in_q [$];
  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  task automatic build_inv_tab();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] s;
      b = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                             input logic last);
    logic [7:0]   s    [16];
    logic [7:0]   t    [16];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r+4*c] = inv_tab[s[r+4*((c-r+4)%4)]] ^ key[127-8*(r+4*c) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) acc = t[r+4*c];
        else begin
          acc = 8'h00;
          for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(coef[(k-r+4)%4], t[k+4*c]);
        end
        res[127-8*(r+4*c) -: 8] = acc;
      end
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Entered and left at posedge+1. Presents the head of in_q (if drive),
  // samples outputs, scores any output transfer, then crosses one edge.
  task automatic cycle(input bit drive, input bit ordy,
                       output logic rdy, output logic oval, output logic [127:0] otext);
    in_valid  = drive && (in_q.size() > 0);
    out_ready = ordy;
    if (in_q.size() > 0) begin
      input_text = in_q[0].in_text;
      round_key  = in_q[0].key;
      last_round = in_q[0].last;
    end
    #1;
    rdy   = in_ready;
    oval  = out_valid;
    otext = output_text;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got %h expected no output", output_text);
      end else begin
        check("stream_data", output_text, exp_q.pop_front());
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_round(in_q[0].in_text, in_q[0].key, in_q[0].last));
      void'(in_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  // Single transfer, checks 2-cycle latency and the result.
  task automatic apply_single(input vec_t v, input string name);
    in_valid   = 1'b1;
    input_text = v.in_text;
    round_key  = v.key;
    last_round = v.last;
    out_ready  = 1'b1;
    #1;
    check({name, "_in_ready"}, 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, 128'(out_valid), 128'(1'b0));
    @(posedge clk); #1;
    check({name, "_lat2_valid"}, 128'(out_valid), 128'(1'b1));
    check({name, "_data"}, output_text, v.exp);
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit rand_mode, input int budget);
    logic         rdy, oval;
    logic [127:0] ot;
    int           n;
    n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      if (rand_mode) cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rdy, oval, ot);
      else           cycle(1'b1, 1'b1, rdy, oval, ot);
      n++;
    end
    if (in_q.size() > 0 || exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", in_q.size() + exp_q.size());
    end
  endtask

  initial begin
    logic         rdy, oval;
    logic [127:0] ot;
    logic [127:0] held;
    int           base;

    // Hand-computed vectors. 0x63 -> 0x00 and 0x09 -> 0x40 under the inverse
    // S-box; a column of four equal bytes is a fixed point of InvMixColumns;
    // the single 0x53 byte becomes 0x50, whose column mixes to 4d e6 bd 46.
    // The last two are rounds 1 and 10 of the FIPS-197 inverse-cipher example.
    vecs[0] = '{{16{8'h63}}, 128'h0, 1'b0, 128'h0};
    vecs[1] = '{{16{8'h63}}, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
                128'h000102030405060708090a0b0c0d0e0f};
    vecs[2] = '{{16{8'h63}}, 128'h01010101020202020303030304040404, 1'b0,
                128'h01010101020202020303030304040404};
    vecs[3] = '{{16{8'h09}}, 128'h0, 1'b1, {16{8'h40}}};
    vecs[4] = '{{16{8'h09}}, 128'h0, 1'b0, {16{8'h40}}};
    vecs[5] = '{{8'h53, {15{8'h63}}}, 128'h0, 1'b0, 128'h4de6bd46000000000000000000000000};
    vecs[6] = '{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e,
                1'b0, 128'h54d990a16ba09ab596bbf40ea111702f};
    // is_box 00102030..f0 XOR key 00010203..0f
    vecs[7] = '{128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f,
                1'b1, 128'h00112233445566778899aabbccddeeff};

    build_inv_tab();

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    input_text = '0; round_key = '0; last_round = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_output",    output_text, 128'h0);
    check("reset_in_ready",  128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;

    // Table vectors, one at a time
    for (int i = 0; i < 8; i++) apply_single(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back throughput
    in_valid = 1'b1; out_ready = 1'b1;
    input_text = vecs[6].in_text; round_key = vecs[6].key; last_round = vecs[6].last;
    #1; check("b2b_ready0", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    input_text = vecs[7].in_text; round_key = vecs[7].key; last_round = vecs[7].last;
    #1; check("b2b_ready1", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid0", 128'(out_valid), 128'(1'b1));
    check("b2b_data0",  output_text, vecs[6].exp);
    @(posedge clk); #1;
    check("b2b_valid1", 128'(out_valid), 128'(1'b1));
    check("b2b_data1",  output_text, vecs[7].exp);
    @(posedge clk); #1;
    check("b2b_idle_valid", 128'(out_valid), 128'(1'b0));
    check("b2b_idle_hold",  output_text, vecs[7].exp);

    // Backpressure: 3 offered, out_ready low for 5 cycles
    in_q.push_back(vecs[5]); in_q.push_back(vecs[6]); in_q.push_back(vecs[7]);
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, 1'b0, rdy, oval, ot);
      check($sformatf("bp_ready%0d", c), 128'(rdy), 128'(c < 2));
      if (c >= 2) begin
        check($sformatf("bp_valid%0d", c), 128'(oval), 128'(1'b1));
        check($sformatf("bp_stable%0d", c), ot, vecs[5].exp);
      end
    end
    drain(1'b0, 20);
    check("bp_count", 128'(n_out - base), 128'(3));

    // Reset while both stages hold data
    in_q.push_back(vecs[0]); in_q.push_back(vecs[6]);
    cycle(1'b1, 1'b0, rdy, oval, ot);
    cycle(1'b1, 1'b0, rdy, oval, ot);
    check("pre_rst_valid", 128'(out_valid), 128'(1'b1));
    check("pre_rst_full",  128'(in_ready), 128'(1'b0));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 128'(out_valid), 128'(1'b0));
    check("rst_mid_data",  output_text, 128'h0);
    check("rst_mid_ready", 128'(in_ready), 128'(1'b1));
    exp_q.delete();
    in_q.delete();
    apply_single(vecs[6], "post_rst");

    // Randomised stream against the model
    base = n_out;
    for (int i = 0; i < 1000; i++) begin
      vec_t v;
      v.in_text = {$urandom, $urandom, $urandom, $urandom};
      v.key     = {$urandom, $urandom, $urandom, $urandom};
      v.last    = 1'($urandom_range(0, 1));
      v.exp     = '0;
      in_q.push_back(v);
    end
    drain(1'b1, 20000);
    check("rand_count", 128'(n_out - base), 128'(1000));

    // Output holds its last value once idle
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    held = output_text;
    repeat (2) @(posedge clk);
    #1;
    check("idle_hold", output_text, held);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
